// File: rtl/banked_sync_ram.sv
// banked_sync_ram: word-addressed synchronous RAM split into 2^BANK_BITS banks.
// After reset every bank is cleared in parallel, one local index per cycle.
// Accesses are accepted only once ready is high. Reads have one cycle of latency.
// Ports:
//   clk      - sole clock; all state updates on the rising edge
//   rst      - synchronous active-high reset
//   cs       - access request; we selects write (1) or read (0)
//   addr     - word address; the top BANK_BITS bits pick the bank
//   wr_data  - write data
//   rd_data  - registered read data
//   rd_valid - one-cycle pulse marking rd_data as new
//   rd_bank  - bank that served the most recent read
//   ready    - high while accesses are accepted
module banked_sync_ram #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BANK_BITS  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cs,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic [BANK_BITS-1:0]  rd_bank,
  output logic                  ready
);

  localparam int unsigned IDX_W  = ADDR_WIDTH - BANK_BITS;
  localparam int unsigned NBANKS = 1 << BANK_BITS;
  localparam int unsigned DEPTH  = 1 << IDX_W;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t                  state;
  state_t                  state_next;
  logic [IDX_W-1:0]        clr_idx;
  logic                    clear_en_c;
  logic                    accept_c;
  logic                    rd_accept_c;
  logic                    wr_accept_c;
  logic [BANK_BITS-1:0]    bank_c;
  logic [IDX_W-1:0]        idx_c;
  logic [DATA_WIDTH-1:0]   mem [NBANKS][DEPTH];

  // Address split: the bank field sits above the local index.
  assign bank_c = addr[ADDR_WIDTH-1 -: BANK_BITS];
  assign idx_c  = addr[IDX_W-1:0];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_CLEAR;
    else     state <= state_next;
  end

  // Next-state logic: leave CLEAR on the cycle the last index is being cleared
  always_comb begin
    state_next = state;
    case (state)
      ST_CLEAR: if (clr_idx == '1) state_next = ST_IDLE;
      ST_IDLE:  state_next = ST_IDLE;
      default:  state_next = ST_CLEAR;
    endcase
  end

  // Output/control decode
  always_comb begin
    clear_en_c  = 1'b0;
    accept_c    = 1'b0;
    rd_accept_c = 1'b0;
    wr_accept_c = 1'b0;
    if (state == ST_CLEAR) clear_en_c = 1'b1;
    accept_c    = cs & ready;
    rd_accept_c = accept_c & ~we;
    wr_accept_c = accept_c & we;
  end

  // Clear index counter
  always_ff @(posedge clk) begin
    if (rst)             clr_idx <= '0;
    else if (clear_en_c) clr_idx <= clr_idx + IDX_W'(1);
  end

  // Storage: clear all banks in parallel, otherwise a single-bank write
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (clear_en_c) begin
        for (int b = 0; b < NBANKS; b++) begin
          mem[BANK_BITS'(b)][clr_idx] <= '0;
        end
      end else if (wr_accept_c) begin
        mem[bank_c][idx_c] <= wr_data;
      end
    end
  end

  // Registered outputs; rd_data/rd_bank hold between reads
  always_ff @(posedge clk) begin
    if (rst) begin
      ready    <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_bank  <= '0;
    end else begin
      ready    <= (state_next == ST_IDLE);
      rd_valid <= rd_accept_c;
      if (rd_accept_c) begin
        rd_data <= mem[bank_c][idx_c];
        rd_bank <= bank_c;
      end
    end
  end

endmodule

// File: tb/tb_banked_sync_ram.sv
// Directed self-checking bench for banked_sync_ram (4 banks x 16 words of 8 bits).
module tb_banked_sync_ram;

  logic       clk;
  logic       rst;
  logic       cs;
  logic       we;
  logic [5:0] addr;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [1:0] rd_bank;
  logic       ready;

  int n_checks = 0;
  int n_fail   = 0;

  banked_sync_ram #(
    .ADDR_WIDTH(6),
    .DATA_WIDTH(8),
    .BANK_BITS (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .cs      (cs),
    .we      (we),
    .addr    (addr),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .rd_valid(rd_valid),
    .rd_bank (rd_bank),
    .ready   (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [5:0] a, input logic [7:0] d);
    cs = 1'b1; we = 1'b1; addr = a; wr_data = d;
    tick();
    check("wr_no_valid", 32'(rd_valid), 32'd0);
  endtask

  task automatic do_read(input logic [5:0] a, input logic [7:0] exp);
    logic [1:0] eb;
    eb = a[5:4];
    cs = 1'b1; we = 1'b0; addr = a;
    tick();
    check("rd_valid", 32'(rd_valid), 32'd1);
    check("rd_data",  32'(rd_data),  32'(exp));
    check("rd_bank",  32'(rd_bank),  32'(eb));
  endtask

  task automatic idle_cycle();
    cs = 1'b0; we = 1'b0;
    tick();
  endtask

  // Count cycles until ready rises (bounded), also counting stray rd_valid pulses.
  task automatic wait_ready(output int n, output int pulses);
    n = 0; pulses = 0;
    while (ready !== 1'b1 && n < 64) begin
      tick();
      n++;
      if (rd_valid === 1'b1) pulses++;
    end
  endtask

  initial begin
    int n;
    int pulses;
    rst = 1'b0; cs = 1'b0; we = 1'b0; addr = '0; wr_data = '0;

    // Reset while a write to 0x00 of 0xFF is held through the whole clear
    rst = 1'b1; cs = 1'b1; we = 1'b1; addr = 6'h00; wr_data = 8'hFF;
    tick();
    check("rst_ready",    32'(ready),    32'd0);
    check("rst_rd_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_data",  32'(rd_data),  32'd0);
    check("rst_rd_bank",  32'(rd_bank),  32'd0);
    rst = 1'b0;
    wait_ready(n, pulses);
    check("clear_len",       32'(n),      32'd16);
    check("clear_no_valid",  32'(pulses), 32'd0);
    cs = 1'b0; we = 1'b0;
    idle_cycle();
    check("idle_no_valid", 32'(rd_valid), 32'd0);
    check("ready_held",    32'(ready),    32'd1);

    // Write attempted during clear must not have landed
    do_read(6'h00, 8'h00);
    idle_cycle();

    // Every address reads zero, back to back
    for (int a = 0; a < 64; a++) do_read(6'(a), 8'h00);
    idle_cycle();
    check("after_sweep_valid", 32'(rd_valid), 32'd0);

    // One word per bank, then back-to-back reads
    do_write(6'h05, 8'hA5);
    do_write(6'h15, 8'h3C);
    do_write(6'h25, 8'h7E);
    do_write(6'h35, 8'hC3);
    do_read(6'h05, 8'hA5);
    do_read(6'h15, 8'h3C);
    do_read(6'h25, 8'h7E);
    do_read(6'h35, 8'hC3);

    // Single read then idle: one pulse, data and bank hold
    do_read(6'h05, 8'hA5);
    for (int i = 0; i < 3; i++) begin
      idle_cycle();
      check("hold_valid", 32'(rd_valid), 32'd0);
      check("hold_data",  32'(rd_data),  32'hA5);
      check("hold_bank",  32'(rd_bank),  32'd0);
    end

    // Read right after write returns new data; same index in other banks untouched
    do_write(6'h2A, 8'h11);
    do_read(6'h2A, 8'h11);
    do_read(6'h0A, 8'h00);
    do_read(6'h1A, 8'h00);
    do_read(6'h3A, 8'h00);
    idle_cycle();

    // Write 0x55 @0x10, then reset coincident with a read
    do_write(6'h10, 8'h55);
    do_read(6'h10, 8'h55);
    rst = 1'b1; cs = 1'b1; we = 1'b0; addr = 6'h05;
    tick();
    check("rst_rd_sup_valid", 32'(rd_valid), 32'd0);
    check("rst_rd_sup_data",  32'(rd_data),  32'd0);
    check("rst2_ready",       32'(ready),    32'd0);
    rst = 1'b0; cs = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("clear2_ready", 32'(ready), 32'd0);
    end
    // Reset again mid-clear: the full clear restarts
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_ready(n, pulses);
    check("clear3_len",      32'(n),      32'd16);
    check("clear3_no_valid", 32'(pulses), 32'd0);
    do_read(6'h10, 8'h00);
    do_read(6'h05, 8'h00);
    idle_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
